half_log2_iter: RTL

- Iterative base-2 logarithm for IEEE-754 half precision: c = log2(a).
- Inverse companion to the team's half-precision 2^x power block; both sit in the half-precision math library.
- Each accepted operand is split into an integer part (the unbiased exponent) and a fractional part, log2 of the mantissa, built one bit per cycle by repeated squaring.
- Fixed-point result is packed back to half with round-to-nearest-even.
- Single operation in flight; valid/ready handshake on both sides.

---
 rtl/half_log2_iter.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/half_log2_iter.sv
// Iterative half-precision log2: integer part from the exponent, fraction bits by repeated squaring,
// result packed to half with round-to-nearest-even. Optional macro HALF_LOG2_SUBNORM_EN normalizes subnormals.
module half_log2_iter #(
   parameter int FRAC_BITS = 12,
   parameter int WORK_W    = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] c
);

   localparam int CNT_W = (FRAC_BITS > 1) ? $clog2(FRAC_BITS) : 1;
   localparam int V_W   = 6 + FRAC_BITS;
   localparam int SH_W  = $clog2(V_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAC_BITS - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      NORM = 3'd1,
      ITER = 3'd2,
      PACK = 3'd3,
      DONE = 3'd4
   } state_t;

   function automatic logic [SH_W-1:0] lead_one(input logic [V_W-1:0] x);
      logic [SH_W-1:0] pos;
      pos = '0;
      for (int i = 0; i < V_W; i++) begin
         if (x[i]) begin
            pos = SH_W'(i);
         end
      end
      return pos;
   endfunction

`ifdef HALF_LOG2_SUBNORM_EN
   function automatic logic [3:0] lzc10(input logic [9:0] m);
      logic [3:0] n;
      n = 4'd10;
      for (int i = 0; i < 10; i++) begin
         if (m[i]) begin
            n = 4'(9 - i);
         end
      end
      return n;
   endfunction
`endif

   state_t                  state_q, state_d;
   logic [15:0]             a_q, a_d;
   logic signed [5:0]       int_q, int_d;
   logic [WORK_W:0]         y_q, y_d;
   logic [FRAC_BITS-1:0]    frac_q, frac_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    force_q, force_d;
   logic [15:0]             spec_q, spec_d;
   logic [15:0]             c_q, c_d;
   logic                    out_valid_q, out_valid_d;

   logic [4:0]              exp_s;
   logic [9:0]              man_s;
   logic                    sgn_s;
   logic                    cls_force_s;
   logic [15:0]             cls_spec_s;
   logic signed [5:0]       norm_int_s;
   logic [WORK_W:0]         norm_y_s;

   logic [2*WORK_W+1:0]     sq_s;
   logic [WORK_W+1:0]       p_trunc_s;
   logic                    iter_bit_s;
   logic [WORK_W:0]         iter_y_s;

   logic signed [V_W-1:0]   v_s;
   logic                    neg_s;
   logic [V_W-1:0]          mag_s;
   logic [SH_W-1:0]         lead_s;
   logic [V_W-1:0]          norm_mag_s;
   logic [10:0]             sig_s;
   logic                    guard_s;
   logic                    sticky_s;
   logic [11:0]             sig_rnd_s;
   logic [4:0]              biased_s;
   logic [15:0]             pack_c_s;
   logic                    unused_s;

   assign exp_s = a_q[14:10];
   assign man_s = a_q[9:0];
   assign sgn_s = a_q[15];

`ifdef HALF_LOG2_SUBNORM_EN
   logic [3:0]  lz_s;
   logic [10:0] sub_man_s;
   assign lz_s      = lzc10(man_s);
   assign sub_man_s = {1'b0, man_s} << (lz_s + 4'd1);
`endif

   // Classify the captured operand and build the starting integer part and working mantissa
   always_comb begin
      cls_force_s = 1'b0;
      cls_spec_s  = 16'h0000;
      norm_int_s  = $signed({1'b0, exp_s}) - 6'sd15;
      norm_y_s    = {1'b1, man_s, {(WORK_W-10){1'b0}}};
      if (exp_s == 5'h1F) begin
         cls_force_s = 1'b1;
         if ((man_s != 10'd0) || sgn_s) begin
            cls_spec_s = 16'h7E00;
         end else begin
            cls_spec_s = 16'h7C00;
         end
      end else if ((exp_s == 5'h00) && (man_s == 10'd0)) begin
         cls_force_s = 1'b1;
         cls_spec_s  = 16'hFC00;
`ifdef HALF_LOG2_SUBNORM_EN
      end else if (sgn_s) begin
         cls_force_s = 1'b1;
         cls_spec_s  = 16'h7E00;
      end else if (exp_s == 5'h00) begin
         norm_int_s = -6'sd15 - $signed({2'b00, lz_s});
         norm_y_s   = {sub_man_s, {(WORK_W-10){1'b0}}};
`else
      end else if (exp_s == 5'h00) begin
         cls_force_s = 1'b1;
         cls_spec_s  = 16'hFC00;
      end else if (sgn_s) begin
         cls_force_s = 1'b1;
         cls_spec_s  = 16'h7E00;
`endif
      end else begin
         cls_force_s = 1'b0;
      end
   end

   // One squaring step: the integer bit of y*y is the next fraction bit of log2
   assign sq_s      = {{(WORK_W+1){1'b0}}, y_q} * {{(WORK_W+1){1'b0}}, y_q};
   assign p_trunc_s = sq_s[2*WORK_W+1:WORK_W];
   assign iter_bit_s = p_trunc_s[WORK_W+1];
   assign iter_y_s   = iter_bit_s ? p_trunc_s[WORK_W+1:1] : p_trunc_s[WORK_W:0];

   // Pack {int,frac} to half: normalize the magnitude so its leading one sits at the MSB, then RNE
   assign v_s        = {int_q, frac_q};
   assign neg_s      = v_s[V_W-1];
   assign mag_s      = neg_s ? $unsigned(-v_s) : $unsigned(v_s);
   assign lead_s     = lead_one(mag_s);
   assign norm_mag_s = mag_s << (SH_W'(V_W - 1) - lead_s);
   assign sig_s      = norm_mag_s[V_W-1 -: 11];
   assign guard_s    = norm_mag_s[V_W-12];
   assign sticky_s   = |norm_mag_s[V_W-13:0];
   assign sig_rnd_s  = {1'b0, sig_s} + {11'd0, guard_s & (sticky_s | sig_s[0])};
   assign biased_s   = 5'(lead_s) + 5'd15 - 5'(FRAC_BITS) + {4'd0, sig_rnd_s[11]};
   assign pack_c_s   = (v_s == '0) ? 16'h0000 : {neg_s, biased_s, sig_rnd_s[9:0]};

   assign unused_s = ^{sq_s[WORK_W-1:0], sig_rnd_s[10]};

   // Next-state and datapath updates
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      int_d       = int_q;
      y_d         = y_q;
      frac_d      = frac_q;
      cnt_d       = cnt_q;
      force_d     = force_q;
      spec_d      = spec_q;
      c_d         = c_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               state_d = NORM;
            end else begin
               state_d = IDLE;
            end
         end
         NORM: begin
            int_d   = norm_int_s;
            y_d     = norm_y_s;
            force_d = cls_force_s;
            spec_d  = cls_spec_s;
            frac_d  = '0;
            cnt_d   = '0;
            state_d = ITER;
         end
         ITER: begin
            y_d    = iter_y_s;
            frac_d = {frac_q[FRAC_BITS-2:0], iter_bit_s};
            if (cnt_q == CNT_LAST) begin
               state_d = PACK;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PACK: begin
            c_d         = force_q ? spec_q : pack_c_s;
            out_valid_d = 1'b1;
            state_d     = DONE;
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= 16'h0000;
         int_q       <= 6'sd0;
         y_q         <= '0;
         frac_q      <= '0;
         cnt_q       <= '0;
         force_q     <= 1'b0;
         spec_q      <= 16'h0000;
         c_q         <= 16'h0000;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         int_q       <= int_d;
         y_q         <= y_d;
         frac_q      <= frac_d;
         cnt_q       <= cnt_d;
         force_q     <= force_d;
         spec_q      <= spec_d;
         c_q         <= c_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign c         = c_q;

endmodule
